// File: rtl/ysyx_22040088_lsu_pkg.sv
// Shared LSU constants: state encoding, memory size codes, writeback selector bits.
package ysyx_22040088_lsu_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned STRB_W = XLEN / 8;
  localparam int unsigned MASK_W = 4;
  localparam int unsigned SEL_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  // One-hot access size codes as produced by the control unit
  localparam logic [MASK_W-1:0] MASK_DWORD = 4'b0001;
  localparam logic [MASK_W-1:0] MASK_WORD  = 4'b0010;
  localparam logic [MASK_W-1:0] MASK_HALF  = 4'b0100;
  localparam logic [MASK_W-1:0] MASK_BYTE  = 4'b1000;

  // Bit positions inside sel_rfres
  localparam int unsigned SEL_ALU  = 0;
  localparam int unsigned SEL_SEXT = 1;
  localparam int unsigned SEL_ZEXT = 2;

  // Bus request payload held while the request is outstanding
  typedef struct packed {
    logic [XLEN-1:0]   addr;
    logic              wen;
    logic [STRB_W-1:0] wstrb;
    logic [XLEN-1:0]   wdata;
  } mem_req_t;

  function automatic logic mask_onehot(input logic [MASK_W-1:0] m);
    return (m != '0) && ((m & (m - MASK_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/ysyx_22040088_lsu_align.sv
// Byte-lane steering: store strobes/data shift, load lane select and extension, alignment check.
module ysyx_22040088_lsu_align
  import ysyx_22040088_lsu_pkg::*;
(
  input  logic [2:0]        addr_lo,
  input  logic [MASK_W-1:0] mask,
  input  logic [XLEN-1:0]   wdata,
  input  logic [XLEN-1:0]   rdata,
  input  logic              sign,
  output logic [STRB_W-1:0] wstrb_c,
  output logic [XLEN-1:0]   wdata_c,
  output logic [XLEN-1:0]   ldata_c,
  output logic              misalign_c
);

  logic [XLEN-1:0] lane;

  // Shift lanes by the byte offset, then size-dependent strobe, extension and alignment
  always_comb begin
    lane       = rdata >> {addr_lo, 3'b000};
    wdata_c    = wdata << {addr_lo, 3'b000};
    wstrb_c    = '0;
    ldata_c    = lane;
    misalign_c = 1'b0;
    case (mask)
      MASK_BYTE: begin
        wstrb_c = STRB_W'(8'h01) << addr_lo;
        ldata_c = {{(XLEN-8){sign & lane[7]}}, lane[7:0]};
      end
      MASK_HALF: begin
        wstrb_c    = STRB_W'(8'h03) << addr_lo;
        ldata_c    = {{(XLEN-16){sign & lane[15]}}, lane[15:0]};
        misalign_c = addr_lo[0];
      end
      MASK_WORD: begin
        wstrb_c    = STRB_W'(8'h0F) << addr_lo;
        ldata_c    = {{(XLEN-32){sign & lane[31]}}, lane[31:0]};
        misalign_c = |addr_lo[1:0];
      end
      MASK_DWORD: begin
        wstrb_c    = STRB_W'(8'hFF);
        ldata_c    = lane;
        misalign_c = |addr_lo;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ysyx_22040088_lsu.sv
// Load/store unit: one instruction in flight, single aligned bus access, result to WBU.
module ysyx_22040088_lsu
  import ysyx_22040088_lsu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mem_ena,
  input  logic              in_mem_wen,
  input  logic [MASK_W-1:0] in_mem_mask,
  input  logic [SEL_W-1:0]  in_sel_rfres,
  input  logic [XLEN-1:0]   in_addr,
  input  logic [XLEN-1:0]   in_wdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [XLEN-1:0]   mem_req_addr,
  output logic              mem_req_wen,
  output logic [STRB_W-1:0] mem_req_wstrb,
  output logic [XLEN-1:0]   mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [XLEN-1:0]   mem_resp_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_data,
  output logic              out_err
);

  lsu_state_e        state;
  mem_req_t          req_r;
  logic [2:0]        r_addr_lo;
  logic [MASK_W-1:0] r_mask;
  logic              r_sign;
  logic              r_wen;

  logic [2:0]        addr_lo_c;
  logic [MASK_W-1:0] mask_c;
  logic [STRB_W-1:0] wstrb_c;
  logic [XLEN-1:0]   wdata_c;
  logic [XLEN-1:0]   ldata_c;
  logic              misalign_c;
  logic              sel_unused_c;

  // ALU-select and zero-extend bits need no logic: zero extension is the default
  assign sel_unused_c = in_sel_rfres[SEL_ALU] ^ in_sel_rfres[SEL_ZEXT];

  assign in_ready = (state == ST_IDLE);

  // Steering sees the incoming instruction while idle, the latched one afterwards
  assign addr_lo_c = (state == ST_IDLE) ? in_addr[2:0] : r_addr_lo;
  assign mask_c    = (state == ST_IDLE) ? in_mem_mask  : r_mask;

  ysyx_22040088_lsu_align u_align (
    .addr_lo    (addr_lo_c),
    .mask       (mask_c),
    .wdata      (in_wdata),
    .rdata      (mem_resp_rdata),
    .sign       (r_sign),
    .wstrb_c    (wstrb_c),
    .wdata_c    (wdata_c),
    .ldata_c    (ldata_c),
    .misalign_c (misalign_c)
  );

  assign mem_req_addr  = req_r.addr;
  assign mem_req_wen   = req_r.wen;
  assign mem_req_wstrb = req_r.wstrb;
  assign mem_req_wdata = req_r.wdata;

  // Control FSM with registered bus request and writeback outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      req_r         <= '0;
      r_addr_lo     <= '0;
      r_mask        <= '0;
      r_sign        <= 1'b0;
      r_wen         <= 1'b0;
      mem_req_valid <= 1'b0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_err       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            r_addr_lo <= in_addr[2:0];
            r_mask    <= in_mem_mask;
            r_sign    <= in_sel_rfres[SEL_SEXT];
            r_wen     <= in_mem_wen;
            if (!in_mem_ena) begin
              out_data  <= in_addr;
              out_err   <= 1'b0;
              out_valid <= 1'b1;
              state     <= ST_DONE;
            end else if (!mask_onehot(in_mem_mask) || misalign_c) begin
              out_data  <= '0;
              out_err   <= 1'b1;
              out_valid <= 1'b1;
              state     <= ST_DONE;
            end else begin
              req_r.addr    <= {in_addr[XLEN-1:3], 3'b000};
              req_r.wen     <= in_mem_wen;
              req_r.wstrb   <= in_mem_wen ? wstrb_c : '0;
              req_r.wdata   <= in_mem_wen ? wdata_c : '0;
              mem_req_valid <= 1'b1;
              state         <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (mem_resp_valid) begin
            out_data  <= r_wen ? '0 : ldata_c;
            out_err   <= 1'b0;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22040088_lsu.sv
// Scoreboard bench for the LSU: random instructions, random bus and WBU backpressure.
module tb_ysyx_22040088_lsu;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_mem_ena;
  logic        in_mem_wen;
  logic [3:0]  in_mem_mask;
  logic [2:0]  in_sel_rfres;
  logic [63:0] in_addr;
  logic [63:0] in_wdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_req_wen;
  logic [7:0]  mem_req_wstrb;
  logic [63:0] mem_req_wdata;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_err;

  ysyx_22040088_lsu dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_mem_ena     (in_mem_ena),
    .in_mem_wen     (in_mem_wen),
    .in_mem_mask    (in_mem_mask),
    .in_sel_rfres   (in_sel_rfres),
    .in_addr        (in_addr),
    .in_wdata       (in_wdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wen    (mem_req_wen),
    .mem_req_wstrb  (mem_req_wstrb),
    .mem_req_wdata  (mem_req_wdata),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_err        (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic        err;
  } exp_out_t;

  typedef struct {
    logic [63:0] addr;
    logic        wen;
    logic [7:0]  wstrb;
    logic [63:0] wdata;
    logic [63:0] rdata;
  } exp_req_t;

  exp_out_t out_q[$];
  exp_req_t req_q[$];

  int checks = 0;
  int errors = 0;
  int issued = 0;
  int delivered = 0;
  int dropped = 0;
  int req_stall_force = -1;
  int out_stall_force = -1;
  bit hold_resp = 1'b0;
  bit awaiting = 1'b0;
  int stray_req = 0;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int size_bytes(input logic [3:0] m);
    case (m)
      4'b0001: return 8;
      4'b0010: return 4;
      4'b0100: return 2;
      4'b1000: return 1;
      default: return 0;
    endcase
  endfunction

  // Reference load: pick nb bytes at byte offset off, then extend
  function automatic logic [63:0] ref_load(input logic [63:0] rd, input int off, input int nb,
                                           input bit sgn);
    logic [63:0] v;
    logic [63:0] m;
    v = rd >> (off * 8);
    if (nb >= 8) return v;
    m = (64'd1 << (nb * 8)) - 64'd1;
    v = v & m;
    if (sgn && v[nb*8-1]) v = v | ~m;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 200) begin
      step();
      n++;
    end
    if (!in_ready) check64("in_ready_timeout", 64'(in_ready), 64'd1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((out_q.size() != 0 || req_q.size() != 0 || !in_ready) && n < 500) begin
      step();
      n++;
    end
    if (out_q.size() != 0) check64("drain_timeout", 64'(out_q.size()), 64'd0);
  endtask

  // Compute expectations, push them to the scoreboard, present the instruction for one cycle
  task automatic issue(input logic ena, input logic wen, input logic [3:0] mask,
                       input logic [2:0] sel, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic [63:0] rdata);
    exp_out_t eo;
    exp_req_t er;
    int nb;
    int off;
    wait_idle();
    nb  = size_bytes(mask);
    off = int'(addr[2:0]);
    if (!ena) begin
      eo.data = addr;
      eo.err  = 1'b0;
    end else if (nb == 0 || (off % nb) != 0) begin
      eo.data = 64'd0;
      eo.err  = 1'b1;
    end else begin
      er.addr  = addr & ~64'd7;
      er.wen   = wen;
      er.wstrb = wen ? 8'(((1 << nb) - 1) << off) : 8'd0;
      er.wdata = wdata << (off * 8);
      er.rdata = rdata;
      req_q.push_back(er);
      eo.data = wen ? 64'd0 : ref_load(rdata, off, nb, sel[1]);
      eo.err  = 1'b0;
    end
    out_q.push_back(eo);
    in_valid     = 1'b1;
    in_mem_ena   = ena;
    in_mem_wen   = wen;
    in_mem_mask  = mask;
    in_sel_rfres = sel;
    in_addr      = addr;
    in_wdata     = wdata;
    step();
    in_valid = 1'b0;
    issued++;
  endtask

  // Bus model: checks requests against the scoreboard, inserts stalls, returns responses
  initial begin : bus
    int stall;
    int resp_wait;
    bit stall_set;
    bit last_v;
    bit last_r;
    int stray_ack;
    logic [63:0] pend_rdata;
    stall = 0; resp_wait = 0; stall_set = 0; last_v = 0; last_r = 0; stray_ack = 0;
    pend_rdata = '0;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    forever begin
      step();
      mem_resp_valid = 1'b0;
      if (!rst_n) begin
        awaiting = 1'b0; mem_req_ready = 1'b0; last_v = 0; last_r = 0; stall_set = 0;
        continue;
      end
      if (last_v && last_r) begin
        if (req_q.size() > 0) begin
          pend_rdata = req_q[0].rdata;
          void'(req_q.pop_front());
        end
        awaiting  = 1'b1;
        resp_wait = $urandom_range(0, 2);
      end
      if (awaiting) begin
        if (!hold_resp) begin
          if (resp_wait == 0) begin
            mem_resp_valid = 1'b1;
            mem_resp_rdata = pend_rdata;
            awaiting = 1'b0;
          end else resp_wait--;
        end
      end else if (!mem_req_valid && (stray_req != stray_ack || $urandom_range(0, 7) == 0)) begin
        stray_ack = stray_req;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = {$urandom, $urandom};
      end
      if (mem_req_valid) begin
        if (req_q.size() == 0) begin
          check64("unexpected_req_addr", mem_req_addr, 64'hx);
          mem_req_ready = 1'b1;
        end else begin
          check64("req_addr", mem_req_addr, req_q[0].addr);
          check64("req_wen", 64'(mem_req_wen), 64'(req_q[0].wen));
          check64("req_wstrb", 64'(mem_req_wstrb), 64'(req_q[0].wstrb));
          if (req_q[0].wen) check64("req_wdata", mem_req_wdata, req_q[0].wdata);
          if (!stall_set) begin
            stall = (req_stall_force >= 0) ? req_stall_force : $urandom_range(0, 2);
            stall_set = 1'b1;
          end
          if (stall > 0) begin
            mem_req_ready = 1'b0;
            stall--;
          end else begin
            mem_req_ready = 1'b1;
            stall_set = 1'b0;
          end
        end
      end else begin
        mem_req_ready = 1'($urandom_range(0, 1));
      end
      last_v = mem_req_valid;
      last_r = mem_req_ready;
    end
  end

  // WBU model: compares each presented result with the scoreboard head, pops on accept
  initial begin : wbu
    int ostall;
    bit oset;
    ostall = 0; oset = 0;
    out_ready = 1'b0;
    forever begin
      step();
      if (!rst_n) begin
        out_ready = 1'b0; oset = 0;
        continue;
      end
      if (out_valid || mem_req_valid) check64("in_ready_busy", 64'(in_ready), 64'd0);
      if (out_valid) begin
        if (out_q.size() == 0) begin
          check64("unexpected_out_valid", 64'(out_valid), 64'd0);
          out_ready = 1'b1;
        end else begin
          check64("out_data", out_data, out_q[0].data);
          check64("out_err", 64'(out_err), 64'(out_q[0].err));
          if (!oset) begin
            ostall = (out_stall_force >= 0) ? out_stall_force : $urandom_range(0, 2);
            oset = 1'b1;
          end
          if (ostall > 0) begin
            out_ready = 1'b0;
            ostall--;
          end else begin
            void'(out_q.pop_front());
            delivered++;
            out_ready = 1'b1;
            oset = 1'b0;
          end
        end
      end else begin
        out_ready = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    int d0;
    int n;
    rst_n = 1'b0;
    in_valid = 1'b0; in_mem_ena = 1'b0; in_mem_wen = 1'b0; in_mem_mask = '0;
    in_sel_rfres = '0; in_addr = '0; in_wdata = '0;
    repeat (3) step();
    check64("rst_in_ready", 64'(in_ready), 64'd1);
    check64("rst_out_valid", 64'(out_valid), 64'd0);
    check64("rst_req_valid", 64'(mem_req_valid), 64'd0);
    check64("rst_out_data", out_data, 64'd0);
    check64("rst_out_err", 64'(out_err), 64'd0);
    check64("rst_req_addr", mem_req_addr, 64'd0);
    check64("rst_req_wstrb", 64'(mem_req_wstrb), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    step();

    // ALU pass-through with one-cycle latency
    issue(1'b0, 1'b0, 4'b0001, 3'b001, 64'h1234, 64'h0, 64'h0);
    check64("pt_latency_out_valid", 64'(out_valid), 64'd1);
    check64("pt_no_req", 64'(mem_req_valid), 64'd0);
    wait_drain();

    // Signed and unsigned byte loads from the same lane
    issue(1'b1, 1'b0, 4'b1000, 3'b010, 64'h8000_0005, 64'h0, 64'h0000_8000_0000_0000);
    wait_drain();
    issue(1'b1, 1'b0, 4'b1000, 3'b100, 64'h8000_0005, 64'h0, 64'h0000_8000_0000_0000);
    wait_drain();

    // Word store into the upper half
    issue(1'b1, 1'b1, 4'b0010, 3'b001, 64'h8000_0004, 64'hDEAD_BEEF, 64'h0);
    wait_drain();

    // Bus and WBU backpressure on a single doubleword load
    d0 = delivered;
    req_stall_force = 3;
    out_stall_force = 2;
    issue(1'b1, 1'b0, 4'b0001, 3'b010, 64'h8000_1000, 64'h0, 64'h8765_4321_0FED_CBA9);
    wait_drain();
    req_stall_force = -1;
    out_stall_force = -1;
    check64("bp_single_result", 64'(delivered), 64'(d0 + 1));

    // Misaligned word and illegal mask: error without a bus access
    issue(1'b1, 1'b0, 4'b0010, 3'b010, 64'h8000_0002, 64'h0, 64'h0);
    wait_drain();
    issue(1'b1, 1'b0, 4'b0000, 3'b010, 64'h8000_0000, 64'h0, 64'h0);
    wait_drain();

    // Random mix
    for (int i = 0; i < 300; i++) begin
      int r;
      int nb;
      logic [3:0] mask;
      logic [63:0] addr;
      r = $urandom_range(0, 9);
      mask = (r == 1) ? 4'($urandom) : (4'b0001 << $urandom_range(0, 3));
      addr = {$urandom, $urandom};
      nb = size_bytes(mask);
      if (r >= 2 && r <= 7 && nb != 0) addr[2:0] = 3'(nb * $urandom_range(0, 8 / nb - 1));
      issue(r != 0, 1'($urandom_range(0, 1)), mask, 3'($urandom), addr,
            {$urandom, $urandom}, {$urandom, $urandom});
      if ($urandom_range(0, 3) == 0) step();
    end
    wait_drain();

    // Reset while waiting for the response, then a stray late response
    hold_resp = 1'b1;
    issue(1'b1, 1'b0, 4'b0010, 3'b010, 64'h8000_2008, 64'h0, 64'hFFFF_FFFF_8000_0000);
    n = 0;
    while (!awaiting && n < 50) begin
      step();
      n++;
    end
    check64("rst_mid_in_resp", 64'(awaiting), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check64("rst_mid_req_valid", 64'(mem_req_valid), 64'd0);
    check64("rst_mid_out_valid", 64'(out_valid), 64'd0);
    check64("rst_mid_out_err", 64'(out_err), 64'd0);
    check64("rst_mid_out_data", out_data, 64'd0);
    check64("rst_mid_req_addr", mem_req_addr, 64'd0);
    check64("rst_mid_in_ready", 64'(in_ready), 64'd1);
    out_q.delete();
    req_q.delete();
    dropped++;
    hold_resp = 1'b0;
    repeat (2) step();
    @(negedge clk) rst_n = 1'b1;
    stray_req++;
    repeat (3) step();
    check64("stray_out_valid", 64'(out_valid), 64'd0);
    check64("stray_in_ready", 64'(in_ready), 64'd1);
    issue(1'b1, 1'b0, 4'b0100, 3'b010, 64'h8000_3006, 64'h0, 64'h9ABC_0000_0000_0000);
    wait_drain();

    check64("delivered_count", 64'(delivered), 64'(issued - dropped));
    check64("scoreboard_empty", 64'(out_q.size() + req_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
